// File: rtl/plic_target_ctrl_if.sv
// Hart-side claim/complete and interrupt signals of one PLIC target context.
interface plic_target_ctrl_if #(
  parameter int SrcWidth = 5
);
  logic                claim_req_i;
  logic                claim_valid_o;
  logic [SrcWidth-1:0] claim_id_o;
  logic                complete_req_i;
  logic [SrcWidth-1:0] complete_id_i;
  logic                irq_o;
  logic [SrcWidth-1:0] irq_id_o;

  modport slave (
    input  claim_req_i, complete_req_i, complete_id_i,
    output claim_valid_o, claim_id_o, irq_o, irq_id_o
  );

  modport master (
    output claim_req_i, complete_req_i, complete_id_i,
    input  claim_valid_o, claim_id_o, irq_o, irq_id_o
  );
endinterface

// File: rtl/plic_target_ctrl.sv
// PLIC gateway plus claim/complete controller for a single target context:
// per-source gateway FSMs, priority max selection and threshold compare.
module plic_target_ctrl #(
  parameter int NumSrc    = 32,
  parameter int PrioWidth = 3,
  parameter int SrcWidth  = $clog2(NumSrc)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumSrc-1:0]                irq_src_i,
  input  logic [NumSrc-1:0]                le_i,
  input  logic [NumSrc-1:0]                ie_i,
  input  logic [NumSrc-1:0][PrioWidth-1:0] prio_i,
  input  logic [PrioWidth-1:0]             threshold_i,
  plic_target_ctrl_if.slave                tgt,
  output logic [NumSrc-1:0]                pending_o
);

  typedef enum logic [1:0] {
    GwIdle     = 2'd0,
    GwPending  = 2'd1,
    GwInflight = 2'd2
  } gw_state_e;

  gw_state_e gw_q [NumSrc];
  gw_state_e gw_d [NumSrc];

  logic [NumSrc-1:0]    prev_q;
  logic [NumSrc-1:0]    edge_seen_q, edge_seen_d;
  logic [NumSrc-1:0]    rise, edge_ev, trig;

  logic [SrcWidth-1:0]  win_id;
  logic [PrioWidth-1:0] win_prio;

  logic                 claim_valid_q, claim_valid_d;
  logic [SrcWidth-1:0]  claim_id_q, claim_id_d;
  logic                 irq_q, irq_d;
  logic [SrcWidth-1:0]  irq_id_q, irq_id_d;

  // Source 0 is reserved; its input bits exist only to keep the vectors uniform.
  logic unused_src0;
  assign unused_src0 = ^{trig[0], edge_ev[0], edge_seen_q[0], ie_i[0], prio_i[0]};

  assign rise    = irq_src_i & ~prev_q;
  assign edge_ev = le_i & rise;
  assign trig    = edge_ev | (~le_i & irq_src_i);

  // Strict greater-than while scanning upward keeps the lowest index on ties.
  always_comb begin
    win_id   = '0;
    win_prio = '0;
    for (int k = 1; k < NumSrc; k++) begin
      if (gw_q[k] == GwPending && ie_i[k] && prio_i[k] > win_prio) begin
        win_id   = SrcWidth'(k);
        win_prio = prio_i[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NumSrc; k++) begin
      gw_d[k] = gw_q[k];
    end
    edge_seen_d    = edge_seen_q;
    gw_d[0]        = GwIdle;
    edge_seen_d[0] = 1'b0;
    for (int k = 1; k < NumSrc; k++) begin
      unique case (gw_q[k])
        GwIdle: begin
          if (trig[k]) gw_d[k] = GwPending;
        end
        GwPending: begin
          if (tgt.claim_req_i && win_id == SrcWidth'(k)) gw_d[k] = GwInflight;
        end
        GwInflight: begin
          if (tgt.complete_req_i && tgt.complete_id_i == SrcWidth'(k)) begin
            // An edge landing in the completion cycle is replayed like a remembered one.
            if (edge_seen_q[k] || edge_ev[k]) begin
              gw_d[k]        = GwPending;
              edge_seen_d[k] = 1'b0;
            end else begin
              gw_d[k] = GwIdle;
            end
          end else if (edge_ev[k]) begin
            edge_seen_d[k] = 1'b1;
          end
        end
        default: gw_d[k] = GwIdle;
      endcase
    end
  end

  always_comb begin
    claim_valid_d = tgt.claim_req_i;
    claim_id_d    = tgt.claim_req_i ? win_id : '0;
    irq_d         = (win_prio > threshold_i);
    irq_id_d      = irq_d ? win_id : '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int k = 0; k < NumSrc; k++) begin
        gw_q[k] <= GwIdle;
      end
      prev_q        <= '0;
      edge_seen_q   <= '0;
      claim_valid_q <= 1'b0;
      claim_id_q    <= '0;
      irq_q         <= 1'b0;
      irq_id_q      <= '0;
    end else begin
      for (int k = 0; k < NumSrc; k++) begin
        gw_q[k] <= gw_d[k];
      end
      prev_q        <= irq_src_i;
      edge_seen_q   <= edge_seen_d;
      claim_valid_q <= claim_valid_d;
      claim_id_q    <= claim_id_d;
      irq_q         <= irq_d;
      irq_id_q      <= irq_id_d;
    end
  end

  always_comb begin
    for (int k = 0; k < NumSrc; k++) begin
      pending_o[k] = (gw_q[k] == GwPending);
    end
  end

  assign tgt.claim_valid_o = claim_valid_q;
  assign tgt.claim_id_o    = claim_id_q;
  assign tgt.irq_o         = irq_q;
  assign tgt.irq_id_o      = irq_id_q;

endmodule

// File: tb/tb_plic_target_ctrl.sv
// Directed self-checking bench for plic_target_ctrl.
module tb_plic_target_ctrl;
  localparam int NumSrc    = 32;
  localparam int PrioWidth = 3;
  localparam int SrcWidth  = 5;

  logic                             clk = 1'b0;
  logic                             rst_n;
  logic [NumSrc-1:0]                irq_src;
  logic [NumSrc-1:0]                le;
  logic [NumSrc-1:0]                ie;
  logic [NumSrc-1:0][PrioWidth-1:0] prio;
  logic [PrioWidth-1:0]             thr;
  logic [NumSrc-1:0]                pending;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  plic_target_ctrl_if #(.SrcWidth(SrcWidth)) tif ();

  plic_target_ctrl #(
    .NumSrc   (NumSrc),
    .PrioWidth(PrioWidth),
    .SrcWidth (SrcWidth)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .irq_src_i  (irq_src),
    .le_i       (le),
    .ie_i       (ie),
    .prio_i     (prio),
    .threshold_i(thr),
    .tgt        (tif),
    .pending_o  (pending)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic claim_chk(input string tag, input int exp_id);
    tif.claim_req_i = 1'b1;
    tick();
    tif.claim_req_i = 1'b0;
    check_eq({tag, "_vld"}, 32'(tif.claim_valid_o), 32'd1);
    check_eq({tag, "_id"}, 32'(tif.claim_id_o), 32'(exp_id));
  endtask

  task automatic complete(input int id);
    tif.complete_req_i = 1'b1;
    tif.complete_id_i  = SrcWidth'(id);
    tick();
    tif.complete_req_i = 1'b0;
    tif.complete_id_i  = '0;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    irq_src = '0;
    le      = '0;
    ie      = '1;
    prio    = '0;
    thr     = '0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset with every source high and a claim in flight
    rst_n              = 1'b0;
    irq_src            = '1;
    le                 = '0;
    ie                 = '1;
    thr                = '0;
    for (int k = 0; k < NumSrc; k++) prio[k] = 3'd1;
    tif.claim_req_i    = 1'b1;
    tif.complete_req_i = 1'b0;
    tif.complete_id_i  = '0;
    tick();
    tick();
    check_eq("rst_irq", 32'(tif.irq_o), 32'd0);
    check_eq("rst_irq_id", 32'(tif.irq_id_o), 32'd0);
    check_eq("rst_claim_vld", 32'(tif.claim_valid_o), 32'd0);
    check_eq("rst_claim_id", 32'(tif.claim_id_o), 32'd0);
    check_eq("rst_pending", 32'(pending), 32'h0);
    rst_n           = 1'b1;
    tif.claim_req_i = 1'b0;
    tick();
    check_eq("rel_pending", 32'(pending), 32'hFFFF_FFFE);
    check_eq("rel_irq_early", 32'(tif.irq_o), 32'd0);
    tick();
    check_eq("rel_irq", 32'(tif.irq_o), 32'd1);
    check_eq("rel_irq_id", 32'(tif.irq_id_o), 32'd1);
    do_reset();

    // Priority ordering with a tie
    prio[3] = 3'd5; prio[7] = 3'd5; prio[9] = 3'd2;
    irq_src[3] = 1'b1; irq_src[7] = 1'b1; irq_src[9] = 1'b1;
    tick();
    tick();
    check_eq("tie_irq", 32'(tif.irq_o), 32'd1);
    check_eq("tie_irq_id", 32'(tif.irq_id_o), 32'd3);
    check_eq("tie_pending", 32'(pending), 32'h0000_0288);
    claim_chk("tie_c3", 3);
    check_eq("tie_pend_after3", 32'(pending), 32'h0000_0280);
    claim_chk("tie_c7", 7);
    claim_chk("tie_c9", 9);
    check_eq("tie_pend_none", 32'(pending), 32'h0);
    claim_chk("tie_c0", 0);
    tick();
    check_eq("tie_irq_off", 32'(tif.irq_o), 32'd0);
    check_eq("tie_lvl_ignored", 32'(pending), 32'h0);
    irq_src = '0;
    complete(3);
    complete(7);
    complete(9);
    tick();
    check_eq("tie_all_idle", 32'(pending), 32'h0);
    do_reset();

    // Threshold masking; claim ignores it
    prio[4]    = 3'd3;
    irq_src[4] = 1'b1;
    thr        = 3'd3;
    tick();
    tick();
    check_eq("thr_eq_irq", 32'(tif.irq_o), 32'd0);
    check_eq("thr_eq_id", 32'(tif.irq_id_o), 32'd0);
    check_eq("thr_pending", 32'(pending), 32'h0000_0010);
    claim_chk("thr_claim", 4);
    tif.complete_req_i = 1'b1;
    tif.complete_id_i  = 5'd4;
    thr                = 3'd2;
    tick();
    tif.complete_req_i = 1'b0;
    check_eq("thr_idle", 32'(pending), 32'h0);
    tick();
    check_eq("thr_rearm", 32'(pending), 32'h0000_0010);
    tick();
    check_eq("thr_lt_irq", 32'(tif.irq_o), 32'd1);
    check_eq("thr_lt_id", 32'(tif.irq_id_o), 32'd4);
    thr = 3'd7;
    tick();
    check_eq("thr_max_irq", 32'(tif.irq_o), 32'd0);
    do_reset();

    // Edge mode: replay of an edge seen while in flight, drops while pending
    le[5]      = 1'b1;
    prio[5]    = 3'd4;
    irq_src[5] = 1'b1;
    tick();
    irq_src[5] = 1'b0;
    check_eq("edge_pend", 32'(pending), 32'h0000_0020);
    claim_chk("edge_c1", 5);
    irq_src[5] = 1'b1;
    tick();
    irq_src[5] = 1'b0;
    check_eq("edge_inflight", 32'(pending), 32'h0);
    complete(5);
    check_eq("edge_replay", 32'(pending), 32'h0000_0020);
    for (int p = 0; p < 2; p++) begin
      irq_src[5] = 1'b1;
      tick();
      irq_src[5] = 1'b0;
      tick();
    end
    claim_chk("edge_c2", 5);
    claim_chk("edge_c3", 0);
    complete(5);
    check_eq("edge_dropped", 32'(pending), 32'h0);
    do_reset();

    // Level re-arm and stray completes
    prio[6]    = 3'd1;
    irq_src[6] = 1'b1;
    tick();
    tick();
    claim_chk("lvl_c1", 6);
    complete(6);
    check_eq("lvl_idle", 32'(pending), 32'h0);
    tick();
    check_eq("lvl_rearm", 32'(pending), 32'h0000_0040);
    irq_src[6] = 1'b0;
    claim_chk("lvl_c2", 6);
    complete(6);
    tick();
    check_eq("lvl_low_idle", 32'(pending), 32'h0);
    complete(6);
    complete(0);
    check_eq("lvl_stray_cmpl", 32'(pending), 32'h0);
    claim_chk("lvl_none", 0);
    do_reset();

    // Claim and complete in the same cycle, then enable masking
    prio[2]    = 3'd6;
    irq_src[2] = 1'b1;
    tick();
    tick();
    claim_chk("sim_c2", 2);
    irq_src[2] = 1'b0;
    prio[8]    = 3'd3;
    irq_src[8] = 1'b1;
    tick();
    check_eq("sim_pend8", 32'(pending), 32'h0000_0100);
    tif.claim_req_i    = 1'b1;
    tif.complete_req_i = 1'b1;
    tif.complete_id_i  = 5'd2;
    tick();
    tif.claim_req_i    = 1'b0;
    tif.complete_req_i = 1'b0;
    check_eq("sim_claim_vld", 32'(tif.claim_valid_o), 32'd1);
    check_eq("sim_claim_id", 32'(tif.claim_id_o), 32'd8);
    check_eq("sim_pend_none", 32'(pending), 32'h0);
    irq_src[2] = 1'b1;
    tick();
    check_eq("sim_src2_idle", 32'(pending), 32'h0000_0004);
    tick();
    check_eq("en_on_irq", 32'(tif.irq_o), 32'd1);
    check_eq("en_on_id", 32'(tif.irq_id_o), 32'd2);
    ie[2] = 1'b0;
    tick();
    check_eq("en_off_irq", 32'(tif.irq_o), 32'd0);
    claim_chk("en_off_claim", 0);
    check_eq("en_off_pend", 32'(pending), 32'h0000_0004);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/plic_target_ctrl.md
# plic_target_ctrl

Interrupt gateway and claim/complete controller for one PLIC target (hart context). It holds per-source gateway state, selects the highest-priority enabled pending source with the same rule as the PLIC priority max tree, and raises the target interrupt when that priority exceeds the target threshold. It sits between the raw interrupt source lines plus the register-file configuration and the hart's claim/complete register accesses.

## Interface
- NumSrc, 32, number of sources including reserved source 0 (≥2)
- PrioWidth, 3, priority field width
- SrcWidth, $clog2(NumSrc), derived; ID width
- clk_i  in  1  clock
- rst_ni  in  1  reset; synchronous, active-low, sampled on rising clk_i
- irq_src_i  in  NumSrc  raw source lines; bit 0 ignored
- le_i  in  NumSrc  per-source mode: 1 = rising-edge, 0 = level
- ie_i  in  NumSrc  per-source enable for this target
- prio_i  in  NumSrc×PrioWidth  per-source priority; 0 = never selected
- threshold_i  in  PrioWidth  target threshold
- claim_req_i  in  1  one-cycle claim strobe (claim register read)
- claim_valid_o  out  1  one-cycle pulse, cycle after claim_req_i
- claim_id_o  out  SrcWidth  claimed ID, valid with claim_valid_o; 0 = nothing claimable
- complete_req_i  in  1  one-cycle complete strobe (complete register write)
- complete_id_i  in  SrcWidth  ID being completed
- irq_o  out  1  registered target interrupt
- irq_id_o  out  SrcWidth  registered ID of current best candidate (0 if none)
- pending_o  out  NumSrc  gateway PENDING bits (for pending register readout)

## Operation
- Per-source gateway FSM (sources 1..NumSrc-1): IDLE, PENDING, INFLIGHT; plus prev_q (edge detect) and edge_seen_q.
- IDLE→PENDING: level mode when irq_src_i[k]=1; edge mode when irq_src_i[k] & ~prev_q[k].
- PENDING→INFLIGHT: source k is the winner on a claim_req_i cycle.
- INFLIGHT→IDLE: complete_req_i with complete_id_i==k; if edge_seen_q[k] set, go to PENDING instead and clear edge_seen_q[k].
- Edge in PENDING: dropped. Edge in INFLIGHT: sets edge_seen_q[k]. Level input in INFLIGHT: ignored; re-evaluated from IDLE after completion.
- Complete for an ID not INFLIGHT, or ID 0, or ID ≥ NumSrc: ignored, no state change.
- Source 0: permanently IDLE, pending_o[0]=0.
- Eligible k: PENDING & ie_i[k] & prio_i[k]≠0. Winner = eligible source with greatest prio_i; ties → smallest index. No eligible source → winner ID 0, winner prio 0.
- Claim ignores threshold: claim_id_o = winner ID at the claim_req_i cycle, else 0 (no state change).
- irq_o_next = (winner prio > threshold_i); irq_id_o_next = winner ID if irq_o_next, else 0.
- Unsigned compares throughout; threshold_i = 2**PrioWidth-1 masks all.
- Claim and complete in the same cycle: both applied; claim cannot select the completed source (it is INFLIGHT at evaluation time).

## Timing
- Reset: all gateways IDLE; prev_q, edge_seen_q 0; irq_o, irq_id_o, claim_valid_o, claim_id_o, pending_o all 0.
- Source asserted in cycle t → pending_o bit set at t+1 → irq_o/irq_id_o at t+2.
- claim_req_i at t → claim_valid_o=1, claim_id_o valid, source INFLIGHT, pending_o bit clear, all at t+1; irq_o reflects the post-claim state at t+2 (may be stale at t+1).
- complete_req_i at t → gateway leaves INFLIGHT at t+1; level source still high → PENDING at t+2, irq_o at t+3.
- Configuration (ie_i, prio_i, threshold_i) changes affect irq_o one cycle later; they never alter gateway state.
- Reset asserted mid-claim: the reset cycle wins; claim_valid_o 0 next cycle, no pending state retained.
- Critical path: NumSrc-wide max selection; single cycle, no pipelining.

## Test plan
- Reset: drive rst_ni=0 with all sources high → all outputs 0 next cycle; release → irq_o=1 two cycles later.
- Priority/tie: sources 3 (prio 5), 7 (prio 5), 9 (prio 2) level high, threshold 0 → irq_id_o=3; claim → claim_id_o=3; next claim → 7; next → 9; next → 0.
- Threshold: single source 4, prio 3; threshold 3 → irq_o=0, claim still returns 4; threshold 2 → irq_o=1.
- Edge mode: source 5 edge, pulse once, claim (ID 5), pulse again while INFLIGHT, complete 5 → pending_o[5]=1 one cycle after completion; two pulses while PENDING → only one claim succeeds.
- Level re-arm: source 6 level held high, claim then complete → PENDING two cycles after complete; complete_id_i=6 while IDLE → no change.
- Simultaneous: complete 2 and claim same cycle with source 8 pending → claim_id_o=8, source 2 IDLE next cycle.
